// File: rtl/lin_interp_up_pkg.sv
// Shared constants for the linear-interpolating upsampler: default widths,
// mode encodings and a segment-length helper.
package lin_interp_up_pkg;

  localparam int unsigned DW_DEF = 8;
  localparam int unsigned MW_DEF = 2;
  localparam int unsigned KW_DEF = (1 << MW_DEF) - 1;
  localparam int unsigned PW_DEF = DW_DEF + 1 + MW_DEF + 1;

  localparam logic [MW_DEF-1:0] MODE_L1 = 2'd0;
  localparam logic [MW_DEF-1:0] MODE_L2 = 2'd1;
  localparam logic [MW_DEF-1:0] MODE_L4 = 2'd2;
  localparam logic [MW_DEF-1:0] MODE_L8 = 2'd3;

  // Number of output points per input interval for a given mode.
  function automatic int unsigned seg_len(input int unsigned m);
    return 32'(1) << m;
  endfunction

endpackage

// File: rtl/lin_interp_up_pt.sv
// Combinational point calculator: y = prev + floor((cur - prev) * k / 2^mode),
// computed with a signed product and an arithmetic shift.
module lin_interp_pt #(
  parameter int unsigned DW = 8,
  parameter int unsigned MW = 2,
  parameter int unsigned KW = 3
) (
  input  logic [DW-1:0] i_prev,
  input  logic [DW-1:0] i_cur,
  input  logic [KW-1:0] i_k,
  input  logic [MW-1:0] i_mode,
  output logic [DW-1:0] o_y
);

  localparam int unsigned PW = DW + 1 + KW;

  logic signed [DW:0]   w_d;
  logic signed [PW-1:0] w_d_ext;
  logic signed [PW-1:0] w_k_ext;
  logic signed [PW-1:0] w_p;
  logic signed [PW-1:0] w_sh;

  assign w_d     = $signed({1'b0, i_cur}) - $signed({1'b0, i_prev});
  assign w_d_ext = PW'(w_d);
  assign w_k_ext = $signed(PW'(i_k));
  assign w_p     = w_d_ext * w_k_ext;
  assign w_sh    = w_p >>> i_mode;

  // The point always lies between prev and cur, so DW-bit modular addition is exact.
  assign o_y = i_prev + DW'(w_sh);

endmodule

// File: rtl/lin_interp_up.sv
// Linear-interpolating upsampler: primes on the first sample, then emits
// 2^mode points per input interval on a straight line between samples.
module lin_interp_up
  import lin_interp_up_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [MW-1:0] mode,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  output logic          din_rdy,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);

  localparam int unsigned KW = (1 << MW) - 1;

  logic [DW-1:0] r_prev;
  logic [DW-1:0] r_cur;
  logic [KW-1:0] r_k;
  logic [MW-1:0] r_mode_q;
  logic          r_have_prev;
  logic          r_have_cur;
  logic [DW-1:0] r_dout;
  logic          r_dout_vld;

  logic [DW-1:0] w_prev_nxt;
  logic [DW-1:0] w_cur_nxt;
  logic [KW-1:0] w_k_nxt;
  logic [MW-1:0] w_mode_nxt;
  logic          w_have_prev_nxt;
  logic          w_have_cur_nxt;
  logic [DW-1:0] w_dout_nxt;
  logic          w_dout_vld_nxt;

  logic [KW-1:0] w_klast;
  logic          w_last;
  logic          w_xfer;
  logic [DW-1:0] w_y;

  lin_interp_pt #(
    .DW (DW),
    .MW (MW),
    .KW (KW)
  ) u_pt (
    .i_prev (r_prev),
    .i_cur  (r_cur),
    .i_k    (r_k),
    .i_mode (r_mode_q),
    .o_y    (w_y)
  );

  assign w_klast  = KW'((1 << r_mode_q) - 1);
  assign w_last   = (r_k == w_klast);
  assign din_rdy  = !r_have_cur || w_last;
  assign w_xfer   = din_vld && din_rdy;
  assign dout     = r_dout;
  assign dout_vld = r_dout_vld;

  // Next-state: segment stepping, back-to-back segment chaining and priming.
  always_comb begin
    w_prev_nxt      = r_prev;
    w_cur_nxt       = r_cur;
    w_k_nxt         = r_k;
    w_mode_nxt      = r_mode_q;
    w_have_prev_nxt = r_have_prev;
    w_have_cur_nxt  = r_have_cur;
    w_dout_nxt      = r_dout;
    w_dout_vld_nxt  = r_have_cur;

    if (r_have_cur) begin
      w_dout_nxt = w_y;
      if (w_last) begin
        w_prev_nxt = r_cur;
        w_k_nxt    = '0;
        if (w_xfer) begin
          w_cur_nxt  = din;
          w_mode_nxt = mode;
        end else begin
          w_have_cur_nxt = 1'b0;
        end
      end else begin
        w_k_nxt = r_k + KW'(1);
      end
    end else if (w_xfer) begin
      if (!r_have_prev) begin
        w_prev_nxt      = din;
        w_have_prev_nxt = 1'b1;
      end else begin
        w_cur_nxt      = din;
        w_have_cur_nxt = 1'b1;
        w_mode_nxt     = mode;
        w_k_nxt        = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev      <= '0;
      r_cur       <= '0;
      r_k         <= '0;
      r_mode_q    <= '0;
      r_have_prev <= 1'b0;
      r_have_cur  <= 1'b0;
      r_dout      <= '0;
      r_dout_vld  <= 1'b0;
    end else begin
      r_prev      <= w_prev_nxt;
      r_cur       <= w_cur_nxt;
      r_k         <= w_k_nxt;
      r_mode_q    <= w_mode_nxt;
      r_have_prev <= w_have_prev_nxt;
      r_have_cur  <= w_have_cur_nxt;
      r_dout      <= w_dout_nxt;
      r_dout_vld  <= w_dout_vld_nxt;
    end
  end

endmodule
